hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Multi-cycle multiply/divide unit with HI/LO registers, in the EX stage of the pipelined MIPS core. It executes the MulOp, MTHILO and MFHILO controls emitted by the decoder: MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO. It reports busy so the hazard unit can stall later HI/LO users.

Parameters:
MUL_CYCLES, 5, busy duration of MULT/MULTU in cycles (>=1)
DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle issue strobe for a mult/div instruction in EX
MulOp  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled only when start=1
A  input  32  rs operand (multiplicand / dividend; MTHI/MTLO data)
B  input  32  rt operand (multiplier / divisor)
HiLoWrite  input  1  MTHI/MTLO issue strobe
MTHILO  input  1  0 = write LO, 1 = write HI; sampled only when HiLoWrite=1
MFHILO  input  2  01 read LO, 10 read HI, 00/11 none
busy  output  1  operation in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
ReadData  output  32  MFHI/MFLO result

Behaviour:
- Reset (synchronous): HI=0, LO=0, busy=0, cycle counter=0, pending result discarded. Reset has priority over every other input, including mid-operation: the in-flight result is never committed.
- States: IDLE and RUN.
- IDLE, start=1 at edge t:
  - latch MulOp, A, B
  - load counter with MUL_CYCLES (MulOp[1]=0) or DIV_CYCLES (MulOp[1]=1)
  - go to RUN; busy=1 from t+1
- RUN: counter decrements each edge. Edge when counter reaches 0:
  - HI/LO take the result
  - busy=0 and state=IDLE, both visible in the same cycle as the new HI/LO
  - busy is high for exactly N cycles (N=MUL_CYCLES or DIV_CYCLES); result visible at edge t+N
- start while busy=1: ignored. The latched operation continues unaffected.
- Back-to-back: start in the first idle cycle after completion is accepted normally.
- Arithmetic:
  - MULTU: {HI,LO} = zero-extended 64-bit product.
  - MULT: {HI,LO} = signed 64-bit product.
  - DIVU: LO = unsigned quotient, HI = unsigned remainder.
  - DIV: quotient truncates toward zero; remainder has the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES busy period runs, HI and LO left unchanged, no exception.
- HiLoWrite:
  - Accepted only when busy=0 and start=0.
  - Selected register takes A at the next edge; the other register is unchanged.
  - Ignored when busy=1.
  - If start and HiLoWrite are both high, start wins and the write is dropped.
- ReadData is combinational:
  - MFHILO=10 gives HI; MFHILO=01 gives LO; any other value gives 0.
  - It reflects current register contents even while busy (stale). The hazard unit must stall MFHI/MFLO and mult/div issue on (busy | start).
- No internal forwarding of the pending result.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5, start pulse -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy=0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIVU A=100, B=7 -> busy 10 cycles, LO=14, HI=2.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero with HI=0x11, LO=0x22 preset via MTHI/MTLO -> busy 10 cycles, HI/LO still 0x11/0x22. Contention case: second start and HiLoWrite pulsed while busy -> ignored, first result committed unchanged.
- Reset asserted on 4th busy cycle of DIVU -> next cycle busy=0, HI=LO=0, and no commit at the original completion edge. Then MTLO A=0x1234 -> LO=0x1234 next edge; MFHILO=01 gives ReadData=0x1234, MFHILO=00 gives 0.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the EX stage: latches operands on start, stays busy
// for a fixed number of cycles per op class, then commits the result to HI/LO.
module hilo_muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  MulOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoWrite,
  input  logic        MTHILO,
  input  logic [1:0]  MFHILO,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] ReadData
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0] prod_u, prod_s;
  logic [31:0] abs_a, abs_b, den_u, den_s;
  logic [31:0] q_u, r_u, q_mag, r_mag, q_s, r_s;
  logic        div_by_zero;
  logic [31:0] res_hi, res_lo;

  // Signed division works on magnitudes and fixes signs afterwards; the
  // 0x80000000 / -1 case falls out naturally because negation wraps.
  always_comb begin
    prod_u      = {32'b0, a_q} * {32'b0, b_q};
    prod_s      = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    abs_a       = a_q[31] ? (~a_q + 32'd1) : a_q;
    abs_b       = b_q[31] ? (~b_q + 32'd1) : b_q;
    div_by_zero = (b_q == '0);
    den_u       = div_by_zero ? 32'd1 : b_q;
    den_s       = div_by_zero ? 32'd1 : abs_b;
    q_u         = a_q / den_u;
    r_u         = a_q % den_u;
    q_mag       = abs_a / den_s;
    r_mag       = abs_a % den_s;
    q_s         = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s         = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    res_hi      = '0;
    res_lo      = '0;
    case (op_q)
      2'b00: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      2'b01: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      2'b10: begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: begin
        res_hi = r_s;
        res_lo = q_s;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = MulOp;
          a_d     = A;
          b_d     = B;
          cnt_d   = MulOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          state_d = S_RUN;
        end else if (HiLoWrite) begin
          if (MTHILO) hi_d = A;
          else        lo_d = A;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!(op_q[1] && div_by_zero)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    case (MFHILO)
      2'b10:   ReadData = hi_q;
      2'b01:   ReadData = lo_q;
      default: ReadData = '0;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_hilo_muldiv_unit;

  localparam int unsigned MUL_N = 5;
  localparam int unsigned DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  MulOp;
  logic [31:0] A, B;
  logic        HiLoWrite;
  logic        MTHILO;
  logic [1:0]  MFHILO;
  logic        busy;
  logic [31:0] HI, LO, ReadData;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_hi, exp_lo;

  hilo_muldiv_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .MulOp(MulOp), .A(A), .B(B),
    .HiLoWrite(HiLoWrite), .MTHILO(MTHILO), .MFHILO(MFHILO),
    .busy(busy), .HI(HI), .LO(LO), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {HI,LO} from the architectural definition using 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint unsigned pu;
    longint          ps, sa, sb, q, r;
    logic [31:0]     qu, ru;
    case (op)
      2'b00: begin
        pu = longint'(a) * longint'(b);
        return pu;
      end
      2'b01: begin
        ps = longint'(int'(a)) * longint'(int'(b));
        return ps;
      end
      2'b10: begin
        qu = a / b;
        ru = a % b;
        return {ru, qu};
      end
      default: begin
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic check_regs(input string tag);
    check_eq({tag, "_hi"}, HI, exp_hi);
    check_eq({tag, "_lo"}, LO, exp_lo);
  endtask

  task automatic check_reads();
    for (int m = 0; m < 4; m++) begin
      MFHILO = 2'(m);
      #1;
      check_eq("readdata", ReadData, (m == 2) ? exp_hi : (m == 1) ? exp_lo : 32'd0);
    end
    MFHILO = 2'b00;
  endtask

  task automatic move_to(input logic sel_hi, input logic [31:0] data);
    HiLoWrite = 1'b1;
    MTHILO    = sel_hi;
    A         = data;
    step();
    HiLoWrite = 1'b0;
    A         = $urandom;
    if (sel_hi) exp_hi = data;
    else        exp_lo = data;
    check_regs("mthilo");
  endtask

  // Issue one op; optionally collide a HiLoWrite with the start, and/or pulse
  // start+HiLoWrite again mid-flight. Neither collision may disturb the result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit contend, input bit write_with_start);
    int unsigned n;
    logic [63:0] r;
    logic [31:0] new_hi, new_lo;
    n = op[1] ? DIV_N : MUL_N;
    if (op[1] && b == 32'd0) begin
      new_hi = exp_hi;
      new_lo = exp_lo;
    end else begin
      r      = ref_result(op, a, b);
      new_hi = r[63:32];
      new_lo = r[31:0];
    end
    start     = 1'b1;
    MulOp     = op;
    A         = a;
    B         = b;
    HiLoWrite = write_with_start;
    MTHILO    = 1'($urandom);
    step();
    start     = 1'b0;
    HiLoWrite = 1'b0;
    A         = $urandom;
    B         = $urandom;
    MulOp     = 2'($urandom);
    for (int k = 0; k < int'(n); k++) begin
      check_eq("busy_run", {31'b0, busy}, 32'd1);
      if (k == int'(n) - 1) check_regs("hold");
      if (contend && k == 1) begin
        start     = 1'b1;
        HiLoWrite = 1'b1;
        MTHILO    = 1'($urandom);
        step();
        start     = 1'b0;
        HiLoWrite = 1'b0;
      end else begin
        step();
      end
    end
    exp_hi = new_hi;
    exp_lo = new_lo;
    check_eq("busy_done", {31'b0, busy}, 32'd0);
    check_regs("result");
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; MulOp = '0; A = '0; B = '0;
    HiLoWrite = 1'b0; MTHILO = 1'b0; MFHILO = '0;
    exp_hi = '0; exp_lo = '0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_regs("rst");

    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_reads();

    move_to(1'b1, 32'h11);
    move_to(1'b0, 32'h22);
    run_op(2'b11, 32'd1234, 32'd0, 1'b0, 1'b0);
    run_op(2'b10, 32'd99, 32'd0, 1'b1, 1'b0);
    run_op(2'b01, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);

    // Reset during the fourth busy cycle of a DIVU must discard the result.
    start = 1'b1; MulOp = 2'b10; A = 32'd1000; B = 32'd3;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check_eq("rst_mid_busy", {31'b0, busy}, 32'd0);
    check_regs("rst_mid");
    for (int k = 0; k < 8; k++) step();
    check_eq("rst_nocommit_busy", {31'b0, busy}, 32'd0);
    check_regs("rst_nocommit");
    move_to(1'b0, 32'h1234);
    check_reads();

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 17));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) move_to(1'($urandom), $urandom);
      run_op(op, ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if (i % 8 == 0) check_reads();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
